onehot_decoder_hold: RTL and testbench

- Inverse of the 16-to-4 priority encoder.
- Accepts a binary index via a valid/ready handshake and drives the matching one-hot line on a registered 16-bit bus.
- The line is held for a programmable number of cycles, then released and the block re-arms.
- Sits between the Pass-Keeper control logic and the per-slot select/enable lines.
- Composing it with the encoder gives a round-trip: index -> one-hot -> same index.

---
 rtl/pk_codec_pkg.sv | 22 ++
 rtl/onehot_decoder_hold.sv | 101 ++++++++++
 tb/tb_onehot_decoder_hold.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pk_codec_pkg.sv
// Shared definitions for the Pass-Keeper index <-> one-hot codec pair.
// Holds the default bus geometry, the decoder state type and the reference one-hot mapping.
package pk_codec_pkg;

    localparam int PK_WIDTH = 16;
    localparam int PK_ENC_W = $clog2(PK_WIDTH);

    typedef enum logic {
        DEC_IDLE = 1'b0,
        DEC_HOLD = 1'b1
    } dec_state_t;

    function automatic logic [PK_WIDTH-1:0] onehot_of(input logic [PK_ENC_W-1:0] index);
        logic [PK_WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < PK_WIDTH; i++) begin
            if (int'(index) == i) result[i] = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/onehot_decoder_hold.sv
// Binary index -> registered one-hot line, held for HOLD_CYCLES cycles before the block re-arms.
// Out-of-range indices (possible only when WIDTH is not a power of two) raise a one-cycle error pulse.
module onehot_decoder_hold
    import pk_codec_pkg::*;
#(
    parameter int WIDTH       = PK_WIDTH,
    parameter int ENC_W       = PK_ENC_W,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ENC_W-1:0] input_encoded,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic             clear,
    output logic [WIDTH-1:0] output_decoded,
    output logic             output_valid,
    output logic             output_error
);

    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    if (ENC_W != $clog2(WIDTH)) begin : g_bad_enc_w
        $error("onehot_decoder_hold: ENC_W must equal clog2(WIDTH)");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
        $error("onehot_decoder_hold: HOLD_CYCLES must be in 1..255");
    end

    dec_state_t        state;
    logic [CNT_W-1:0]  hold_cnt;
    logic [WIDTH-1:0]  decoded_next;
    logic              index_in_range;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        decoded_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(input_encoded) == i) decoded_next[i] = 1'b1;
        end
    end

    assign index_in_range = int'(input_encoded) < WIDTH;

    // input_ready doubles as the "in IDLE" flag, so the accept term needs no state decode.
    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= DEC_IDLE;
            hold_cnt       <= '0;
            output_decoded <= '0;
            output_valid   <= 1'b0;
            input_ready    <= 1'b1;
            output_error   <= 1'b0;
        end else if (clear) begin
            state          <= DEC_IDLE;
            hold_cnt       <= '0;
            output_decoded <= '0;
            output_valid   <= 1'b0;
            input_ready    <= 1'b1;
            output_error   <= 1'b0;
        end else begin
            case (state)
                DEC_IDLE: begin
                    output_error <= 1'b0;
                    if (input_valid && input_ready) begin
                        if (index_in_range) begin
                            state          <= DEC_HOLD;
                            hold_cnt       <= CNT_W'(HOLD_CYCLES - 1);
                            output_decoded <= decoded_next;
                            output_valid   <= 1'b1;
                            input_ready    <= 1'b0;
                        end else begin
                            output_error <= 1'b1;
                        end
                    end
                end
                DEC_HOLD: begin
                    output_error <= 1'b0;
                    if (hold_cnt == '0) begin
                        state          <= DEC_IDLE;
                        output_decoded <= '0;
                        output_valid   <= 1'b0;
                        input_ready    <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state          <= DEC_IDLE;
                    hold_cnt       <= '0;
                    output_decoded <= '0;
                    output_valid   <= 1'b0;
                    input_ready    <= 1'b1;
                    output_error   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_decoder_hold.sv
// Self-checking bench: a 16-line/hold-4 decoder and a 12-line/hold-1 decoder run against a
// cycles-remaining behavioural model, plus hand-computed directed expectations.
module tb_onehot_decoder_hold;

    localparam int WID  [2] = '{16, 12};
    localparam int HOLD [2] = '{4, 1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  enc [2];
    logic        vld [2];
    logic        rdy0, rdy1, val0, val1, err0, err1;
    logic [15:0] dec0;
    logic [11:0] dec1;

    int checks = 0;
    int errors = 0;

    int hold_left [2];
    int m_idx     [2];
    bit m_err     [2];

    always #5 clk = ~clk;

    onehot_decoder_hold #(.WIDTH(16), .ENC_W(4), .HOLD_CYCLES(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .input_encoded(enc[0]), .input_valid(vld[0]),
        .input_ready(rdy0), .clear(clear), .output_decoded(dec0),
        .output_valid(val0), .output_error(err0)
    );

    onehot_decoder_hold #(.WIDTH(12), .ENC_W(4), .HOLD_CYCLES(1)) dut12 (
        .clk(clk), .rst_n(rst_n), .input_encoded(enc[1]), .input_valid(vld[1]),
        .input_ready(rdy1), .clear(clear), .output_decoded(dec1),
        .output_valid(val1), .output_error(err1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: highest set line wins; a one-hot input returns its own index.
    function automatic int encode16(input logic [15:0] d);
        int r = 0;
        for (int i = 0; i < 16; i++) if (d[i]) r = i;
        return r;
    endfunction

    // Model: each accepted in-range index keeps its line live for HOLD more cycles.
    always @(posedge clk or negedge rst_n) begin
        for (int n = 0; n < 2; n++) begin
            m_err[n] = 1'b0;
            if (!rst_n || clear) begin
                hold_left[n] = 0;
            end else if (hold_left[n] > 0) begin
                hold_left[n] = hold_left[n] - 1;
            end else if (vld[n] === 1'b1) begin
                if (int'(enc[n]) < WID[n]) begin
                    hold_left[n] = HOLD[n];
                    m_idx[n]     = int'(enc[n]);
                end else begin
                    m_err[n] = 1'b1;
                end
            end
        end
    end

    function automatic logic [15:0] exp_dec(input int n);
        logic [15:0] one = 16'd1;
        return (hold_left[n] > 0) ? (one << m_idx[n]) : 16'd0;
    endfunction

    always @(negedge clk) begin
        check("dec16", {16'd0, dec0}, {16'd0, exp_dec(0)});
        check("val16", {31'd0, val0}, {31'd0, hold_left[0] > 0});
        check("rdy16", {31'd0, rdy0}, {31'd0, hold_left[0] == 0});
        check("err16", {31'd0, err0}, {31'd0, m_err[0]});
        check("dec12", {20'd0, dec1}, {16'd0, exp_dec(1)});
        check("val12", {31'd0, val1}, {31'd0, hold_left[1] > 0});
        check("rdy12", {31'd0, rdy1}, {31'd0, hold_left[1] == 0});
        check("err12", {31'd0, err1}, {31'd0, m_err[1]});
    end

    logic [15:0] b2b_seq [10];

    initial begin
        enc[0] = '0; enc[1] = '0; vld[0] = 1'b0; vld[1] = 1'b0;

        // Reset for three cycles, then idle.
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_dec", {16'd0, dec0}, 32'h0);
        check("idle_rdy", {31'd0, rdy0}, 32'h1);

        // Single decode of index 0xA: 0x0400 for four cycles, then released.
        enc[0] = 4'hA; vld[0] = 1'b1;
        @(posedge clk); #1 vld[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("single_dec", {16'd0, dec0}, 32'h0400);
            check("single_rdy", {31'd0, rdy0}, 32'h0);
        end
        @(negedge clk);
        check("single_rel_dec", {16'd0, dec0}, 32'h0);
        check("single_rel_rdy", {31'd0, rdy0}, 32'h1);

        // Back-to-back with valid held high: index 0, one idle cycle, then index 15.
        b2b_seq = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000,
                    16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000};
        enc[0] = 4'd0; vld[0] = 1'b1;
        @(posedge clk); #1 enc[0] = 4'd15;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("b2b_dec", {16'd0, dec0}, {16'd0, b2b_seq[i]});
            if (i == 5) vld[0] = 1'b0;
        end

        // Clear on the second hold cycle of index 3.
        enc[0] = 4'd3; vld[0] = 1'b1;
        @(posedge clk); #1 vld[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        check("clear_dec", {16'd0, dec0}, 32'h0);
        check("clear_rdy", {31'd0, rdy0}, 32'h1);

        // Clear in IDLE blocks a simultaneous accept.
        clear = 1'b1; enc[0] = 4'd5; vld[0] = 1'b1;
        @(posedge clk); #1 clear = 1'b0; vld[0] = 1'b0;
        @(negedge clk);
        check("clear_blocks_val", {31'd0, val0}, 32'h0);

        // Asynchronous reset between edges while holding index 7.
        enc[0] = 4'd7; vld[0] = 1'b1;
        @(posedge clk); #1 vld[0] = 1'b0;
        @(negedge clk);
        check("pre_rst_dec", {16'd0, dec0}, 32'h0080);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dec", {16'd0, dec0}, 32'h0);
        check("async_rst_rdy", {31'd0, rdy0}, 32'h1);
        #10 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_val", {31'd0, val0}, 32'h0);

        // WIDTH = 12: index 13 is out of range, index 11 decodes with a one-cycle hold.
        enc[1] = 4'd13; vld[1] = 1'b1;
        @(posedge clk); #1 vld[1] = 1'b0;
        @(negedge clk);
        check("oor_err", {31'd0, err1}, 32'h1);
        check("oor_val", {31'd0, val1}, 32'h0);
        @(negedge clk);
        check("oor_err_pulse", {31'd0, err1}, 32'h0);
        enc[1] = 4'd11; vld[1] = 1'b1;
        @(posedge clk); #1 vld[1] = 1'b0;
        @(negedge clk);
        check("w12_dec", {20'd0, dec1}, 32'h0800);
        @(negedge clk);
        check("w12_rel", {20'd0, dec1}, 32'h0);

        // Round trip through the reference encoder for all 16 indices.
        for (int idx = 0; idx < 16; idx++) begin
            enc[0] = 4'(idx); vld[0] = 1'b1;
            @(posedge clk); #1 vld[0] = 1'b0;
            @(negedge clk);
            check("round_trip", encode16(dec0), idx);
            repeat (4) @(negedge clk);
        end

        // Randomised traffic on both instances, rare clears.
        repeat (3000) begin
            @(negedge clk);
            vld[0] = 1'($urandom_range(0, 1));
            vld[1] = 1'($urandom_range(0, 1));
            enc[0] = 4'($urandom_range(0, 15));
            enc[1] = 4'($urandom_range(0, 15));
            clear  = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        vld[0] = 1'b0; vld[1] = 1'b0; clear = 1'b0;
        repeat (8) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
